// File: rtl/wr_sched_pkg.sv
// -----------------------------------------------------------------------------
// wr_sched_pkg
// Shared definitions for the write-channel scheduler:
//   - wr_sched_state_e : transaction FSM states (IDLE, ISSUE, WAIT, COMMIT)
//   - MAX_REQ          : largest supported requester count
//   - IDX_W            : width of a requester index at MAX_REQ
//   - onehot_to_idx()  : one-hot vector to binary index
// -----------------------------------------------------------------------------
package wr_sched_pkg;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } wr_sched_state_e;

    // OR of the indices of all set bits; exact for a one-hot or all-zero input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wr_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// wr_sched_rr_arb
// Combinational round-robin pick. Scans requesters starting at ptr_i and
// wrapping modulo NUM_REQ; the first requester found with req_i set wins.
// The pointer itself is owned by the parent.
// Ports:
//   req_i  [NUM_REQ-1:0]  request vector
//   ptr_i  [PTR_W-1:0]    first requester to consider (must be < NUM_REQ)
//   pick_o [NUM_REQ-1:0]  one-hot winner, all-zero when no request
// -----------------------------------------------------------------------------
module wr_sched_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] idx_s;
    logic             found_s;

    // Rotating priority scan starting at ptr_i.
    always_comb begin
        pick_o  = {NUM_REQ{1'b0}};
        found_s = 1'b0;
        idx_s   = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, ptr_i} + SUM_W'(i);
            if (idx_s >= SUM_W'(NUM_REQ)) begin
                idx_s = idx_s - SUM_W'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_i[idx_s[PTR_W-1:0]]) begin
                pick_o[idx_s[PTR_W-1:0]] = 1'b1;
                found_s                  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/wr_channel_sched.sv
// -----------------------------------------------------------------------------
// wr_channel_sched
// Shares one write channel (do_wr / wr_valid / ready) between NUM_REQ
// requesters. Each write runs IDLE -> ISSUE -> WAIT -> COMMIT; the valid bit
// of the winning requester is captured at grant time and is the value
// presented on wr_valid for the whole transaction.
//
// Optional feature macro: WR_SCHED_TIMEOUT_EN
//   Defined   : a wait counter aborts a transaction after TIMEOUT_CYC cycles
//               in WAIT, pulsing timeout and advancing the RR pointer.
//   Undefined : no counter, timeout tied low, WAIT is unbounded.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req        in   [NUM_REQ] level request per requester
//   req_valid  in   [NUM_REQ] valid bit each requester wants written
//   grant      out  [NUM_REQ] one-hot owner of the current transaction
//   done       out  [NUM_REQ] one-cycle pulse to the owner on commit
//   do_wr      out  write strobe to target (ISSUE and COMMIT)
//   wr_valid   out  write valid bit to target
//   ready      in   target ready
//   busy       out  transaction in flight
//   timeout    out  one-cycle abort pulse (feature macro only)
// -----------------------------------------------------------------------------
module wr_channel_sched
    import wr_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               do_wr,
    output logic               wr_valid,
    input  logic               ready,
    output logic               busy,
    output logic               timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    wr_sched_state_e    state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               was_valid_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               do_wr_q;
    logic               wr_valid_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] pick_s;
    logic               pick_valid_s;
    logic [PTR_W-1:0]   owner_s;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] done_s;

`ifdef WR_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]   wait_cnt_q;
    logic               timeout_q;
`endif

    wr_sched_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick_s)
    );

    // The winner's valid bit is the value committed for this transaction.
    assign pick_valid_s = |(req_valid & pick_s);

    // Binary index of the current owner; grant_q is one-hot or zero.
    assign owner_s = PTR_W'(onehot_to_idx(MAX_REQ'(grant_q)));

    // Pointer moves to the requester after the owner, wrapping at NUM_REQ.
    always_comb begin
        if (owner_s == PTR_W'(NUM_REQ - 1)) begin
            ptr_d = {PTR_W{1'b0}};
        end else begin
            ptr_d = owner_s + PTR_W'(1);
        end
    end

    // done must line up with the COMMIT cycle in which ready is seen, so it is
    // decoded from the registered state and grant rather than delayed a cycle.
    always_comb begin
        if ((state_q == COMMIT) && ready) begin
            done_s = grant_q;
        end else begin
            done_s = {NUM_REQ{1'b0}};
        end
    end

    // Transaction FSM with registered channel outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= {NUM_REQ{1'b0}};
            was_valid_q <= 1'b0;
            ptr_q       <= {PTR_W{1'b0}};
            do_wr_q     <= 1'b0;
            wr_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef WR_SCHED_TIMEOUT_EN
            wait_cnt_q  <= {CNT_W{1'b0}};
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef WR_SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q     <= ISSUE;
                        grant_q     <= pick_s;
                        was_valid_q <= pick_valid_s;
                        do_wr_q     <= 1'b1;
                        wr_valid_q  <= pick_valid_s;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        grant_q     <= {NUM_REQ{1'b0}};
                        do_wr_q     <= 1'b0;
                        wr_valid_q  <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Single-cycle strobe; ready is not sampled here.
                    state_q    <= WAIT;
                    do_wr_q    <= 1'b0;
                    wr_valid_q <= was_valid_q;
`ifdef WR_SCHED_TIMEOUT_EN
                    wait_cnt_q <= {CNT_W{1'b0}};
`endif
                end
                WAIT: begin
                    if (ready) begin
                        state_q <= COMMIT;
                        do_wr_q <= 1'b1;
                    end
`ifdef WR_SCHED_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Last permitted WAIT cycle without ready: abort.
                        state_q    <= IDLE;
                        grant_q    <= {NUM_REQ{1'b0}};
                        ptr_q      <= ptr_d;
                        do_wr_q    <= 1'b0;
                        wr_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        timeout_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                        do_wr_q    <= 1'b0;
                    end
`else
                    else begin
                        do_wr_q <= 1'b0;
                    end
`endif
                end
                COMMIT: begin
                    if (ready) begin
                        state_q    <= IDLE;
                        grant_q    <= {NUM_REQ{1'b0}};
                        ptr_q      <= ptr_d;
                        do_wr_q    <= 1'b0;
                        wr_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        // Target withdrew ready: retry the commit from WAIT.
                        state_q <= WAIT;
                        do_wr_q <= 1'b0;
`ifdef WR_SCHED_TIMEOUT_EN
                        wait_cnt_q <= {CNT_W{1'b0}};
`endif
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= {NUM_REQ{1'b0}};
                    do_wr_q    <= 1'b0;
                    wr_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign done     = done_s;
    assign do_wr    = do_wr_q;
    assign wr_valid = wr_valid_q;
    assign busy     = busy_q;

`ifdef WR_SCHED_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule
